// File: rtl/comp_pkg.sv
// Shared definitions for the comparator debounce stage: FSM state codes and
// a helper that classifies the comparator's flag vector.
package comp_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] BELOW   = 2'd0;
  localparam logic [ST_W-1:0] RISING  = 2'd1;
  localparam logic [ST_W-1:0] ABOVE   = 2'd2;
  localparam logic [ST_W-1:0] FALLING = 2'd3;

  typedef enum logic [1:0] {
    FLAGS_NONE   = 2'd0,
    FLAGS_ONEHOT = 2'd1,
    FLAGS_MULTI  = 2'd2
  } flags_t;

  function automatic flags_t flags_chk(input logic ag, input logic eq, input logic bg);
    logic [1:0] n;
    n = {1'b0, ag} + {1'b0, eq} + {1'b0, bg};
    case (n)
      2'd0:    return FLAGS_NONE;
      2'd1:    return FLAGS_ONEHOT;
      default: return FLAGS_MULTI;
    endcase
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// Up-counter that sticks at all-ones; used for event counting across the filter.
module sat_cnt #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         INC,
  output logic [W-1:0] Q
);

  always_ff @(posedge CLK) begin
    if (RST)
      Q <= '0;
    else if (INC && (Q != {W{1'b1}}))
      Q <= Q + 1'b1;
  end

endmodule

// File: rtl/comp_debounce.sv
// Persistence/hysteresis stage behind the comparator: LEVEL changes only after
// HOLD consecutive valid qualifying samples, with rise/fall pulses and a rise count.
//
// state   | meaning
// BELOW   | LEVEL=0, no run in progress
// RISING  | LEVEL=0, counting consecutive A>B samples
// ABOVE   | LEVEL=1, no run in progress
// FALLING | LEVEL=1, counting consecutive B>A samples
module comp_debounce
  import comp_pkg::*;
#(
  parameter int HOLD  = 3,
  parameter int CNT_W = 4,
  parameter int EVT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VLD,
  input  logic             AG,
  input  logic             EQ,
  input  logic             BG,
  output logic             LEVEL,
  output logic             RISE,
  output logic             FALL,
  output logic [EVT_W-1:0] EVT_CNT,
  output logic             ERR
);

  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(HOLD);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [ST_W-1:0]  state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
  logic             rise_nxt, fall_nxt, err_nxt;
  flags_t           fl;

  assign fl      = flags_chk(AG, EQ, BG);
  assign cnt_inc = cnt + 1'b1;

  // Only a one-hot valid sample can move the FSM; EQ never advances or breaks a run.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    err_nxt   = 1'b0;
    if (VLD) begin
      if (fl == FLAGS_MULTI) begin
        err_nxt = 1'b1;
      end else if (fl == FLAGS_ONEHOT) begin
        case (state)
          BELOW: if (AG) begin
            if (HOLD_C == CNT_ONE) begin
              state_nxt = ABOVE;
              rise_nxt  = 1'b1;
            end else begin
              state_nxt = RISING;
              cnt_nxt   = CNT_ONE;
            end
          end
          RISING: if (AG) begin
            if (cnt_inc == HOLD_C) begin
              state_nxt = ABOVE;
              cnt_nxt   = '0;
              rise_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else if (BG) begin
            state_nxt = BELOW;
            cnt_nxt   = '0;
          end
          ABOVE: if (BG) begin
            if (HOLD_C == CNT_ONE) begin
              state_nxt = BELOW;
              fall_nxt  = 1'b1;
            end else begin
              state_nxt = FALLING;
              cnt_nxt   = CNT_ONE;
            end
          end
          default: if (BG) begin
            if (cnt_inc == HOLD_C) begin
              state_nxt = BELOW;
              cnt_nxt   = '0;
              fall_nxt  = 1'b1;
            end else begin
              cnt_nxt = cnt_inc;
            end
          end else if (AG) begin
            state_nxt = ABOVE;
            cnt_nxt   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= BELOW;
      cnt   <= '0;
      LEVEL <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      LEVEL <= (state_nxt == ABOVE) || (state_nxt == FALLING);
      RISE  <= rise_nxt;
      FALL  <= fall_nxt;
      ERR   <= err_nxt;
    end
  end

  sat_cnt #(.W(EVT_W)) u_evt (
    .CLK (CLK),
    .RST (RST),
    .INC (rise_nxt),
    .Q   (EVT_CNT)
  );

endmodule

// File: tb/tb_comp_debounce.sv
// Scoreboard bench for comp_debounce: two configurations driven in lockstep,
// expectations from a run-length reference model queued per cycle.
module tb_comp_debounce;

  typedef struct {
    logic lvl;
    logic rise;
    logic fall;
    logic err;
    int   evt;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       VLD = 1'b0;
  logic       AG = 1'b0, EQ = 1'b0, BG = 1'b0;
  logic       lvl_a, rise_a, fall_a, err_a;
  logic       lvl_b, rise_b, fall_b, err_b;
  logic [7:0] evt_a;
  logic [1:0] evt_b;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_lvl[2], m_run[2], m_evt[2];
  int   m_hold[2] = '{3, 1};
  int   m_emax[2] = '{255, 3};
  exp_t q_a[$];
  exp_t q_b[$];

  always #5 CLK = ~CLK;

  comp_debounce #(.HOLD(3), .CNT_W(4), .EVT_W(8)) dut_a (
    .CLK(CLK), .RST(RST), .VLD(VLD), .AG(AG), .EQ(EQ), .BG(BG),
    .LEVEL(lvl_a), .RISE(rise_a), .FALL(fall_a), .EVT_CNT(evt_a), .ERR(err_a)
  );

  comp_debounce #(.HOLD(1), .CNT_W(4), .EVT_W(2)) dut_b (
    .CLK(CLK), .RST(RST), .VLD(VLD), .AG(AG), .EQ(EQ), .BG(BG),
    .LEVEL(lvl_b), .RISE(rise_b), .FALL(fall_b), .EVT_CNT(evt_b), .ERR(err_b)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: LEVEL flips once the run of the opposing flag reaches HOLD.
  function automatic exp_t model_step(input int i, input logic rst, input logic vld,
                                      input logic ag, input logic eq, input logic bg);
    exp_t e;
    int   nset;
    logic adv, brk;
    e.rise = 1'b0; e.fall = 1'b0; e.err = 1'b0;
    nset = int'(ag) + int'(eq) + int'(bg);
    if (rst) begin
      m_lvl[i] = 0; m_run[i] = 0; m_evt[i] = 0;
    end else if (vld && nset > 1) begin
      e.err = 1'b1;
    end else if (vld && nset == 1) begin
      adv = (m_lvl[i] == 0) ? ag : bg;
      brk = (m_lvl[i] == 0) ? bg : ag;
      if (adv) m_run[i]++;
      if (brk) m_run[i] = 0;
      if (m_run[i] >= m_hold[i]) begin
        m_run[i] = 0;
        if (m_lvl[i] == 0) begin
          m_lvl[i] = 1;
          e.rise = 1'b1;
          if (m_evt[i] < m_emax[i]) m_evt[i]++;
        end else begin
          m_lvl[i] = 0;
          e.fall = 1'b1;
        end
      end
    end
    e.lvl = (m_lvl[i] != 0);
    e.evt = m_evt[i];
    return e;
  endfunction

  task automatic cyc(input string tag, input logic rst, input logic vld,
                     input logic ag, input logic eq, input logic bg);
    exp_t ea, eb;
    @(negedge CLK);
    RST = rst; VLD = vld; AG = ag; EQ = eq; BG = bg;
    q_a.push_back(model_step(0, rst, vld, ag, eq, bg));
    q_b.push_back(model_step(1, rst, vld, ag, eq, bg));
    @(posedge CLK);
    #1;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk({tag, " a.level"}, int'(lvl_a),  int'(ea.lvl));
    chk({tag, " a.rise"},  int'(rise_a), int'(ea.rise));
    chk({tag, " a.fall"},  int'(fall_a), int'(ea.fall));
    chk({tag, " a.err"},   int'(err_a),  int'(ea.err));
    chk({tag, " a.evt"},   int'(evt_a),  ea.evt);
    chk({tag, " b.level"}, int'(lvl_b),  int'(eb.lvl));
    chk({tag, " b.rise"},  int'(rise_b), int'(eb.rise));
    chk({tag, " b.fall"},  int'(fall_b), int'(eb.fall));
    chk({tag, " b.err"},   int'(err_b),  int'(eb.err));
    chk({tag, " b.evt"},   int'(evt_b),  eb.evt);
  endtask

  task automatic smp(input string tag, input logic ag, input logic eq, input logic bg);
    cyc(tag, 1'b0, 1'b1, ag, eq, bg);
  endtask

  initial begin
    int   r;
    logic rr, vv;
    cyc("reset0", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("reset1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);

    // three AG samples: rise only on the third
    smp("rise1", 1, 0, 0);
    smp("rise2", 1, 0, 0);
    smp("rise3", 1, 0, 0);
    cyc("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) smp("down", 0, 0, 1);

    // broken run then clean run
    smp("brk_ag1", 1, 0, 0);
    smp("brk_ag2", 1, 0, 0);
    smp("brk_bg",  0, 0, 1);
    smp("brk_ag3", 1, 0, 0);
    smp("brk_ag4", 1, 0, 0);
    smp("brk_ag5", 1, 0, 0);

    // EQ inside a falling run
    smp("fall_bg1", 0, 0, 1);
    smp("fall_eq1", 0, 1, 0);
    smp("fall_eq2", 0, 1, 0);
    smp("fall_bg2", 0, 0, 1);
    smp("fall_bg3", 0, 0, 1);

    // illegal and empty flag sets mid-run
    smp("err_pre", 1, 0, 0);
    smp("err_11",  1, 0, 1);
    smp("err_000", 0, 0, 0);
    smp("err_111", 1, 1, 1);
    smp("err_ag",  1, 0, 0);
    smp("err_ag2", 1, 0, 0);

    // VLD gaps do not break a run
    repeat (3) smp("gap_dn", 0, 0, 1);
    smp("gap_ag1", 1, 0, 0);
    cyc("gap_v0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    smp("gap_ag2", 1, 0, 0);
    cyc("gap_v0b", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    smp("gap_ag3", 1, 0, 0);

    // alternating samples: saturates the 2-bit counter on the HOLD=1 instance
    for (int i = 0; i < 5; i++) begin
      smp("alt_bg", 0, 0, 1);
      smp("alt_ag", 1, 0, 0);
    end

    // reset mid-run discards the partial count
    smp("rst_dn", 0, 0, 1);
    cyc("rst_clr", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    smp("rst_ag1", 1, 0, 0);
    smp("rst_ag2", 1, 0, 0);
    cyc("rst_mid", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    smp("rst_ag3", 1, 0, 0);
    smp("rst_ag4", 1, 0, 0);
    smp("rst_ag5", 1, 0, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 7);
      vv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 99) == 0);
      if (r == 7) r = 1;
      cyc("rand", rr, vv, r[2], r[1], r[0]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_debounce.md
# comp_debounce

Persistence/hysteresis stage directly downstream of the parametric comparator in the IIR filter datapath. Consumes the comparator's one-hot A>B / A==B / B>A flags plus a sample-valid strobe. Asserts a registered level only after HOLD consecutive valid A>B samples, and clears it only after HOLD consecutive valid B>A samples. Emits single-cycle rise/fall pulses and a saturating rise-event count for overflow and threshold monitoring.

## Interface
- HOLD, 3, number of consecutive qualifying samples required to change LEVEL; legal range 1 .. 2^CNT_W-1
- CNT_W, 4, width of the persistence counter
- EVT_W, 8, width of the saturating rise-event counter
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  reset, synchronous, active-high
- VLD  input  1  flags valid this cycle
- AG  input  1  comparator A>B flag
- EQ  input  1  comparator A==B flag
- BG  input  1  comparator B>A flag
- LEVEL  output  1  debounced "A above B" level, registered
- RISE  output  1  one-cycle pulse when LEVEL goes 0->1
- FALL  output  1  one-cycle pulse when LEVEL goes 1->0
- EVT_CNT  output  EVT_W  count of RISE events, saturating at all-ones
- ERR  output  1  one-cycle pulse: VLD with more than one flag set

## Operation
- A sample is processed only when VLD=1. With VLD=0, state, counter and outputs hold, except pulses, which clear.
- A sample with all flags at 0 (the comparator's reset output) is ignored, with no ERR.
- A sample with 2 or 3 flags set pulses ERR and is otherwise ignored.
- FSM states (2-bit): BELOW=0, RISING=1, ABOVE=2, FALLING=3. LEVEL=1 in ABOVE and FALLING.
- BELOW:
  - AG: if HOLD==1, go to ABOVE and pulse RISE; otherwise go to RISING with cnt=1.
  - EQ or BG: stay.
- RISING:
  - AG: cnt+1; when cnt+1==HOLD, go to ABOVE, cnt=0, pulse RISE.
  - BG: go to BELOW, cnt=0.
  - EQ: hold state and cnt (neither advances nor breaks the run).
- ABOVE: mirror of BELOW, with BG as the qualifying flag and FALL as the pulse; goes to FALLING with cnt=1.
- FALLING: mirror of RISING.
  - BG advances cnt; reaching HOLD goes to BELOW and pulses FALL.
  - AG returns to ABOVE with cnt=0.
  - EQ holds.
- EVT_CNT increments on every RISE and stops at 2^EVT_W-1; it is never decremented.
- cnt never exceeds HOLD-1, so it never wraps.

## Timing
- Reset values: state=BELOW, cnt=0, LEVEL=0, RISE=0, FALL=0, ERR=0, EVT_CNT=0.
- RST has priority over VLD in the same cycle.
- Reset asserted mid-run discards the partial count.
- Latency: the HOLD-th consecutive qualifying sample sampled at edge N gives LEVEL, RISE/FALL and the EVT_CNT update all visible after edge N.
- RISE, FALL and ERR are high for exactly one cycle.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.
- Non-consecutive VLD cycles still count as consecutive samples; gaps in VLD do not break a run.

## Structure
- Shared package comp_pkg holds:
  - state encodings BELOW/RISING/ABOVE/FALLING and the 2-bit state width;
  - a flags-legality function returning {none, one-hot, multi}.
- Sub-module sat_cnt (parameter W; ports CLK, RST, INC, Q) implements EVT_CNT and is reused elsewhere in the filter.
- FSM and persistence counter live in comp_debounce.

## Test plan
- HOLD=3, after reset; VLD=1 with AG for 3 cycles -> LEVEL=1 and RISE pulse after the 3rd edge; EVT_CNT=1; no RISE after 2 samples.
- HOLD=3, in BELOW; samples AG, AG, BG, AG, AG, AG -> LEVEL rises only after the 6th sample; exactly one RISE.
- HOLD=3, in ABOVE; samples BG, EQ, EQ, BG, BG -> FALL pulse after the 5th sample; LEVEL=0; EQ neither advances nor breaks the run.
- Samples {AG,BG}=11 and {AG,EQ,BG}=000 with VLD=1 -> ERR pulses only for 11; state and cnt unchanged for both.
- EVT_W=2, HOLD=1; 5 alternating AG/BG rise cycles -> EVT_CNT goes 1, 2, 3, 3, 3.
- HOLD=3, after 2 AG samples assert RST for one cycle, then 1 AG sample -> LEVEL stays 0 and state is RISING with cnt=1.
